// File: rtl/chord_sequencer_pkg.sv
// Shared types and ROM word layout for the chord sequencer.
package chord_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ROMWAIT,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int ROM_W    = 16;
  localparam int EOS_BIT  = 15;
  localparam int ADV_BIT  = 14;
  localparam int NOTE_MSB = 11;
  localparam int NOTE_LSB = 6;
  localparam int DUR_MSB  = 5;
  localparam int DUR_LSB  = 0;
  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;

  // Decoded song word; reserved bits [13:12] are dropped.
  typedef struct packed {
    logic              eos;
    logic              adv;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_word_t;

endpackage

// File: rtl/chord_sequencer_if.sv
// Song ROM bus plus the note-load side towards the voice block.
interface chord_sequencer_if #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 7
);
  logic                                 play;
  logic [SONG_BITS-1:0]                 song;
  logic                                 beat;
  logic                                 note_done;
  logic [SONG_BITS+IDX_BITS-1:0]        rom_addr;
  logic [chord_seq_pkg::ROM_W-1:0]      rom_data;
  logic [chord_seq_pkg::NOTE_W-1:0]     note_to_load;
  logic [chord_seq_pkg::DUR_W-1:0]      duration;
  logic                                 load_new_note;
  logic                                 song_done;

  // Sequencer side.
  modport master (
    input  play, song, beat, note_done, rom_data,
    output rom_addr, note_to_load, duration, load_new_note, song_done
  );

  // Environment side: ROM, transport controls and voice block.
  modport slave (
    output play, song, beat, note_done, rom_data,
    input  rom_addr, note_to_load, duration, load_new_note, song_done
  );
endinterface

// File: rtl/chord_sequencer_beat_countdown.sv
// Beat countdown: load on issue, decrement on counted beats, flag zero.

// Enabled D flip-flop with async active-low clear.
module dffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Plain storage element; holds when en is low.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
endmodule

module beat_countdown import chord_seq_pkg::*; (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             tick,
  output logic             zero
);
  logic [DUR_W-1:0] count;
  logic [DUR_W-1:0] count_d;
  logic             count_en;

  // Load wins over a same-cycle tick; the counter never underflows.
  assign zero     = (count == '0);
  assign count_en = load | (tick & ~zero);
  assign count_d  = load ? load_val : count - DUR_W'(1);

  dffre #(.W(DUR_W)) u_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (count_en),
    .d     (count_d),
    .q     (count)
  );
endmodule

// File: rtl/chord_sequencer.sv
// Walks a song ROM and issues note loads to the chords voice block.
module chord_sequencer import chord_seq_pkg::*; #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 7
) (
  input logic               clk,
  input logic               reset,
  chord_sequencer_if.master bus
);
  localparam logic [IDX_BITS-1:0] IDX_MAX = '1;

  state_t                        state, state_nxt;
  logic [IDX_BITS-1:0]           idx, idx_nxt;
  logic [SONG_BITS-1:0]          song_q, song_nxt;
  logic                          last, last_nxt;
  logic                          adv_q;
  logic [NOTE_W-1:0]             note_q;
  logic [DUR_W-1:0]              dur_q;
  logic [SONG_BITS+IDX_BITS-1:0] addr_q;
  logic                          capture, strobe, cnt_load, cnt_tick, cnt_zero;
  rom_word_t                     word;
  logic                          rsvd_unused;

  assign word.eos    = bus.rom_data[EOS_BIT];
  assign word.adv    = bus.rom_data[ADV_BIT];
  assign word.note   = bus.rom_data[NOTE_MSB:NOTE_LSB];
  assign word.dur    = bus.rom_data[DUR_MSB:DUR_LSB];
  assign rsvd_unused = ^bus.rom_data[13:12];

  beat_countdown u_beats (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (dur_q),
    .tick     (cnt_tick),
    .zero     (cnt_zero)
  );

  // Next-state logic; every paused state simply holds.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    song_nxt  = song_q;
    last_nxt  = last;
    capture   = 1'b0;
    strobe    = 1'b0;
    cnt_load  = 1'b0;
    cnt_tick  = 1'b0;
    unique case (state)
      S_IDLE: if (bus.play) begin
        song_nxt  = bus.song;
        idx_nxt   = '0;
        last_nxt  = 1'b0;
        state_nxt = S_FETCH;
      end
      S_FETCH: if (bus.play) state_nxt = S_ROMWAIT;
      S_ROMWAIT: if (bus.play) begin
        if (word.eos) state_nxt = S_DRAIN;
        else begin
          capture   = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: if (bus.play) begin
        strobe   = 1'b1;
        cnt_load = 1'b1;
        // idx saturates on the final entry so the address never wraps to 0.
        if (idx == IDX_MAX) last_nxt = 1'b1;
        else                idx_nxt  = idx + IDX_BITS'(1);
        if (adv_q)               state_nxt = S_WAIT;
        else if (idx == IDX_MAX) state_nxt = S_DRAIN;
        else                     state_nxt = S_FETCH;
      end
      S_WAIT: if (bus.play) begin
        if (cnt_zero) state_nxt = last ? S_DRAIN : S_FETCH;
        else          cnt_tick  = bus.beat;
      end
      S_DRAIN: if (bus.play && bus.note_done) state_nxt = S_DONE;
      S_DONE: if (bus.play && (bus.song != song_q)) begin
        song_nxt  = bus.song;
        idx_nxt   = '0;
        last_nxt  = 1'b0;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, position and address registers; the address tracks the next idx.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      song_q <= '0;
      last   <= 1'b0;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      song_q <= song_nxt;
      last   <= last_nxt;
      addr_q <= {song_nxt, idx_nxt};
    end

  // Note fields captured from ROM; they stay put until the next capture.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      note_q <= '0;
      dur_q  <= '0;
      adv_q  <= 1'b0;
    end else if (capture) begin
      note_q <= word.note;
      dur_q  <= word.dur;
      adv_q  <= word.adv;
    end

  assign bus.rom_addr      = addr_q;
  assign bus.note_to_load  = note_q;
  assign bus.duration      = dur_q;
  assign bus.load_new_note = strobe;
  assign bus.song_done     = (state == S_DONE);
endmodule
